synch_fifo_param: RTL

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. It also fixes error semantics: errors pulse only on rejected requests. It sits between a producer and a consumer in the same clock domain, anywhere the design needs elastic buffering with early back-pressure.

---
 rtl/synch_fifo_param_if.sv | 31 +++
 rtl/synch_fifo_param.sv | 87 ++++++++
 2 files changed

// File: rtl/synch_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and synch_fifo_param.
interface synch_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();

  logic                     wr_en;
  logic [WIDTH-1:0]         w_data_in;
  logic                     rd_en;
  logic [WIDTH-1:0]         r_data_out;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     wr_error;
  logic                     rd_error;

  // Producer/consumer side.
  modport master (
    output wr_en, w_data_in, rd_en,
    input  r_data_out, full, empty, almost_full, almost_empty, count, wr_error, rd_error
  );

  // FIFO side.
  modport slave (
    input  wr_en, w_data_in, rd_en,
    output r_data_out, full, empty, almost_full, almost_empty, count, wr_error, rd_error
  );

endinterface

// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, rejected-request error pulses and optional FWFT read mode.
module synch_fifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input logic               clk,
  input logic               rst,
  synch_fifo_param_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_error_q, rd_error_q;
  logic             wr_accept, rd_accept;
  logic             full, empty;

  // Flag decode, request acceptance and next occupancy.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    rd_accept = bus.rd_en && !empty;
    // A write into a full FIFO is fine when a pop frees a slot on the same edge.
    wr_accept = bus.wr_en && (!full || rd_accept);
    count_d   = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.wr_error     = wr_error_q;
  assign bus.rd_error     = rd_error_q;

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_accept) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      wr_error_q <= bus.wr_en && !wr_accept;
      rd_error_q <= bus.rd_en && !rd_accept;
    end
  end

  // Storage; contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= bus.w_data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.r_data_out = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] r_data_q;

    // Registered read data; holds across idle and rejected reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q <= '0;
      end else if (rd_accept) begin
        r_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus.r_data_out = r_data_q;
  end

endmodule
